// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM/owner encodings and defaults for the IF/LS memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned AddrWidth          = 32;
    localparam int unsigned DataWidth          = 32;
    localparam int unsigned StrbWidth          = 4;
    localparam int unsigned StarveWidth        = 4;
    localparam int unsigned StarveLimitDefault = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    typedef enum logic {
        OwnerIf = 1'b0,
        OwnerLs = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant decision for the shared memory port: LS priority with an IF anti-starvation counter.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic if_valid,
    input  logic ls_valid,
    output logic grant_if,
    output logic grant_ls
);

    localparam logic [StarveWidth-1:0] Limit = StarveWidth'(STARVE_LIMIT);

    logic [StarveWidth-1:0] starve_q, starve_d;
    logic                   if_wins;

    always_comb begin
        if_wins  = if_valid && (!ls_valid || (starve_q == Limit));
        grant_if = idle && if_wins;
        grant_ls = idle && ls_valid && !if_wins;

        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (grant_ls && if_valid && (starve_q != Limit)) begin
            // Only LS grants that actually bypass a waiting fetch count as starvation.
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store masters onto one memory port, one
// transaction outstanding, with responses routed back to the owning master.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 if_req_valid_i,
    input  logic [AddrWidth-1:0] if_req_addr_i,
    output logic                 if_req_ready_o,
    output logic                 if_rsp_valid_o,
    output logic [DataWidth-1:0] if_rsp_data_o,

    input  logic                 ls_req_valid_i,
    input  logic [AddrWidth-1:0] ls_req_addr_i,
    input  logic                 ls_req_we_i,
    input  logic [StrbWidth-1:0] ls_req_wstrb_i,
    input  logic [DataWidth-1:0] ls_req_wdata_i,
    output logic                 ls_req_ready_o,
    output logic                 ls_rsp_valid_o,
    output logic [DataWidth-1:0] ls_rsp_data_o,

    output logic                 mem_req_valid_o,
    output logic [AddrWidth-1:0] mem_req_addr_o,
    output logic                 mem_req_we_o,
    output logic [StrbWidth-1:0] mem_req_wstrb_o,
    output logic [DataWidth-1:0] mem_req_wdata_o,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_rsp_valid_i,
    input  logic [DataWidth-1:0] mem_rsp_data_i
);

    state_e                 state_q, state_d;
    owner_e                 owner_q, owner_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;

    logic idle;
    logic active;
    logic grant_if;
    logic grant_ls;

    // Gating with rst_n keeps the combinational readies low while reset is held.
    assign idle   = rst_n && (state_q == StIdle);
    assign active = (state_q == StIssue) || (state_q == StWait);

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle     (idle),
        .if_valid (if_req_valid_i),
        .ls_valid (ls_req_valid_i),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;

        mem_req_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_ls) begin
                    owner_d = OwnerLs;
                    addr_d  = ls_req_addr_i;
                    we_d    = ls_req_we_i;
                    wstrb_d = ls_req_wstrb_i;
                    wdata_d = ls_req_wdata_i;
                    state_d = StIssue;
                end else if (grant_if) begin
                    owner_d = OwnerIf;
                    addr_d  = if_req_addr_i;
                    we_d    = 1'b0;
                    wstrb_d = '0;
                    wdata_d = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = mem_rsp_valid_i ? StIdle : StWait;
                end
            end
            StWait: begin
                if (mem_rsp_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        if_req_ready_o  = grant_if;
        ls_req_ready_o  = grant_ls;

        mem_req_addr_o  = addr_q;
        mem_req_we_o    = we_q;
        mem_req_wstrb_o = wstrb_q;
        mem_req_wdata_o = wdata_q;

        if_rsp_valid_o  = 1'b0;
        if_rsp_data_o   = '0;
        ls_rsp_valid_o  = 1'b0;
        ls_rsp_data_o   = '0;

        if (active) begin
            if (owner_q == OwnerIf) begin
                if_rsp_valid_o = mem_rsp_valid_i;
                if_rsp_data_o  = mem_rsp_data_i;
            end else begin
                ls_rsp_valid_o = mem_rsp_valid_i;
                ls_rsp_data_o  = mem_rsp_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= OwnerIf;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive LS grants while IF waits (range 1..15).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have if_req_valid_i  input  1 and if_req_addr_i  input  32: fetch request and PC.
REQ-005 SHALL have if_req_ready_o  output  1  fetch request accepted this cycle when valid&ready.
REQ-006 SHALL have if_rsp_valid_o  output  1 and if_rsp_data_o  output  32: instruction return.
REQ-007 SHALL have ls_req_valid_i  input  1, ls_req_addr_i  input  32, ls_req_we_i  input  1, ls_req_wstrb_i  input  4, ls_req_wdata_i  input  32: load/store request.
REQ-008 SHALL have ls_req_ready_o  output  1, ls_rsp_valid_o  output  1, ls_rsp_data_o  output  32.
REQ-009 SHALL have mem_req_valid_o  output  1, mem_req_addr_o  output  32, mem_req_we_o  output  1, mem_req_wstrb_o  output  4, mem_req_wdata_o  output  32: shared memory port request.
REQ-010 SHALL have mem_req_ready_i  input  1, mem_rsp_valid_i  input  1, mem_rsp_data_i  input  32: memory accept and response.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT; one transaction outstanding at a time.
REQ-012 IDLE: if_req_ready_o/ls_req_ready_o SHALL be high only for the winner, combinationally, and only in IDLE; loser ready low.
REQ-013 Arbitration SHALL be LS-priority, except IF wins when starve counter == STARVE_LIMIT.
REQ-014 Starve counter (4 bit) SHALL increment, saturating at STARVE_LIMIT, on each LS grant while if_req_valid_i high; SHALL clear on any IF grant.
REQ-015 On grant, request fields SHALL be registered into holding regs, owner register set (IF/LS), FSM -> ISSUE next cycle; IF grants force we=0, wstrb=0, wdata=0.
REQ-016 ISSUE: mem_req_valid_o high, mem_req_* from holding regs, stable until mem_req_ready_i; on ready -> WAIT.
REQ-017 mem_req_ready_i and mem_rsp_valid_i both high in ISSUE SHALL complete the transaction, -> IDLE directly.
REQ-018 WAIT: mem_req_valid_o low; on mem_rsp_valid_i -> IDLE.
REQ-019 Response SHALL route combinationally: owner's rsp_valid_o = mem_rsp_valid_i in ISSUE/WAIT, rsp_data_o = mem_rsp_data_i; non-owner valid 0, data 0.
REQ-020 Stores SHALL also complete only on mem_rsp_valid_i; data forwarded unchanged.
REQ-021 mem_rsp_valid_i in IDLE SHALL be ignored, no master response.
REQ-022 Minimum latency: grant cycle N, mem_req_valid_o at N+1, response earliest at N+1 (same-cycle accept+rsp), next grant at N+2.
REQ-023 Back-to-back: new grant allowed in the cycle IDLE is re-entered.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, owner=IF, starve counter 0, holding regs 0.
REQ-025 During reset all outputs SHALL be 0 (all ready/valid low, all data/addr 0).
REQ-026 Reset mid-transaction SHALL drop the in-flight transaction; no response delivered for it after reset release.

Structure
REQ-027 Shared package SHALL hold address/data/strobe width constants, FSM state encoding, owner encoding, STARVE_LIMIT default.
REQ-028 Grant decision plus starve counter SHALL be one sub-module, arb_pick; FSM, holding regs and routing stay in mem_arbiter.

Verification
REQ-029 IF-only: IF req addr 0x0000_0010, mem ready same cycle, rsp 0x0000_0013 next -> if_rsp_valid_o 1 cycle, data 0x0000_0013, ls outputs 0.
REQ-030 Simultaneous IF and LS load (addr 0x8000_0000) in IDLE -> LS granted, IF ready low; IF granted after LS response.
REQ-031 STARVE_LIMIT=4, LS and IF valid continuously -> grant sequence LS,LS,LS,LS,IF, then counter 0, LS again.
REQ-032 Store addr 0x8000_0004, wstrb 0x3, wdata 0xDEAD_BEEF, mem_req_ready_i held low 3 cycles -> mem_req_* stable 3 cycles, single accept, ls_rsp_valid_o on response.
REQ-033 rst_n low during WAIT, mem_rsp_valid_i pulsed after release -> no rsp_valid to either master, FSM IDLE.
REQ-034 mem_req_ready_i and mem_rsp_valid_i high together in ISSUE -> response delivered, next grant following cycle.
